// File: rtl/seg_scan_if.sv
// Shadow-digit write and commit handshake bundle for seg_scan_ctrl.
// The master is the digit producer; the slave is the scan controller.
interface seg_scan_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       commit;
  logic       commit_done;

  modport master (
    output wr_valid, wr_addr, wr_data, commit,
    input  wr_ready, commit_done
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, commit,
    output wr_ready, commit_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed display scanner with shadow/active digit banks and frame-aligned commit.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_ctrl #(
  parameter int PRESCALE = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  seg_scan_if.slave        wr,
  output logic             frame_tick,
  output logic [3:0]       d,
  output logic [5:0]       seg_sel
);

  localparam logic [9:0] PRE = 10'(PRESCALE);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [9:0]      cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            pend_q, pend_d;
  logic [5:0][3:0] shadow_q, shadow_d;
  logic [5:0][3:0] active_q, active_d;
  logic [3:0]      d_q, d_d;
  logic [5:0]      sel_q, sel_d;
  logic            tick_q, tick_d;
  logic            done_q, done_d;
  logic            show;

  function automatic logic [5:0] slot_sel(input logic [2:0] k);
    return 6'h20 >> k;
  endfunction

`ifdef SEG_LZB_EN
  // Slot k is blank while every digit from slot 0 through k is zero; slot 5 always shows.
  function automatic logic lz_blank(input logic [2:0] k, input logic [5:0][3:0] act);
    logic z;
    z = 1'b1;
    for (int i = 0; i < 5; i++)
      if (i <= int'(k) && act[i] != 4'h0) z = 1'b0;
    return z && (k < 3'd5);
  endfunction
`endif

  assign wr.wr_ready    = !pend_q;
  assign wr.commit_done = done_q;
  assign frame_tick     = tick_q;
  assign d              = d_q;
  assign seg_sel        = sel_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    active_d = active_q;
    d_d      = 4'h0;
    sel_d    = 6'h00;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    show     = 1'b0;

    // Writes to slots 6/7 are accepted by the handshake but land nowhere.
    if (wr.wr_valid && !pend_q && wr.wr_addr <= 3'd5)
      shadow_d[wr.wr_addr] = wr.wr_data;
    // Uses pend_q, so a commit landing on the applying edge waits for the next boundary.
    if (wr.commit && !pend_q)
      pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (pend_q) begin
          active_d = shadow_q;
          pend_d   = 1'b0;
          done_d   = 1'b1;
        end
        if (enable) begin
          state_d = SCAN;
          show    = 1'b1;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          show = 1'b1;
          if (cnt_q == PRE) begin
            cnt_d = '0;
            if (idx_q == 3'd5) begin
              idx_d  = '0;
              tick_d = 1'b1;
              if (pend_q) begin
                active_d = shadow_q;
                pend_d   = 1'b0;
                done_d   = 1'b1;
              end
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Display registers load from the post-commit bank so a new frame shows new data at once.
    if (show) begin
      d_d   = active_d[idx_d];
      sel_d = slot_sel(idx_d);
`ifdef SEG_LZB_EN
      if (lz_blank(idx_d, active_d)) begin
        d_d   = 4'h0;
        sel_d = 6'h00;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
      d_q      <= 4'h0;
      sel_q    <= 6'h00;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      d_q      <= d_d;
      sel_q    <= sel_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with PRESCALE=3 (4 cycles per slot, 24 per frame).
// cyc counts rising edges since scan start; outputs are sampled on the falling edge.
module tb_seg_scan_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       frame_tick;
  logic [3:0] d;
  logic [5:0] seg_sel;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = -1;

  seg_scan_if bus();

  seg_scan_ctrl #(.PRESCALE(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .wr         (bus),
    .frame_tick (frame_tick),
    .d          (d),
    .seg_sel    (seg_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(negedge clk);
    cyc++;
  endtask

  task automatic wr_slot(input logic [2:0] a, input logic [3:0] v);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = v;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (d !== 4'h0) begin n_fail++; $display("FAIL rst_d got %h want 0", d); end
    n_cmp++; if (seg_sel !== 6'h00) begin n_fail++; $display("FAIL rst_sel got %h want 00", seg_sel); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick got %b want 0", frame_tick); end
    n_cmp++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", bus.commit_done); end
    n_cmp++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", bus.wr_ready); end
  endtask

  task automatic test_scan;
    int slot;
    logic [5:0] es;
    enable = 1'b1;
    reset = 1'b0;
    cyc = -1;
    repeat (49) begin
      step();
      slot = (cyc % 24) / 4;
      es = 6'h20 >> slot;
`ifdef SEG_LZB_EN
      if (slot < 5) es = 6'h00;
`endif
      n_cmp++; if (seg_sel !== es) begin n_fail++; $display("FAIL scan_sel cyc=%0d got %h want %h", cyc, seg_sel, es); end
      n_cmp++; if (d !== 4'h0) begin n_fail++; $display("FAIL scan_d cyc=%0d got %h want 0", cyc, d); end
      n_cmp++; if (frame_tick !== (cyc % 24 == 0 && cyc != 0)) begin n_fail++;
        $display("FAIL scan_tick cyc=%0d got %b want %b", cyc, frame_tick, (cyc % 24 == 0 && cyc != 0)); end
    end
  endtask

  task automatic test_commit;
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL cm_ready_pre k=%0d got %b want 1", k, bus.wr_ready); end
      wr_slot(3'(k), 4'(k + 1));
    end
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL cm_ready_pend got %b want 0", bus.wr_ready); end
    while (cyc < 71) begin
      step();
      n_cmp++; if (d !== 4'h0) begin n_fail++; $display("FAIL cm_early_d cyc=%0d got %h want 0", cyc, d); end
      n_cmp++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL cm_early_done cyc=%0d got %b want 0", cyc, bus.commit_done); end
    end
    step();
    n_cmp++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL cm_tick got %b want 1", frame_tick); end
    n_cmp++; if (bus.commit_done !== 1'b1) begin n_fail++; $display("FAIL cm_done got %b want 1", bus.commit_done); end
    n_cmp++; if (seg_sel !== 6'h20) begin n_fail++; $display("FAIL cm_sel got %h want 20", seg_sel); end
    n_cmp++; if (d !== 4'h1) begin n_fail++; $display("FAIL cm_d0 got %h want 1", d); end
    n_cmp++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL cm_ready_post got %b want 1", bus.wr_ready); end
    repeat (23) begin
      step();
      n_cmp++; if (d !== 4'((cyc % 24) / 4 + 1)) begin n_fail++;
        $display("FAIL cm_d cyc=%0d got %h want %0h", cyc, d, (cyc % 24) / 4 + 1); end
      n_cmp++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL cm_done_once cyc=%0d got %b want 0", cyc, bus.commit_done); end
    end
  endtask

  task automatic test_commit_on_tick;
    step();
    for (int k = 0; k < 6; k++) wr_slot(3'(k), 4'(9 - k));
    while (cyc < 119) step();
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    n_cmp++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL ot_tick got %b want 1", frame_tick); end
    n_cmp++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL ot_done_defer got %b want 0", bus.commit_done); end
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL ot_ready got %b want 0", bus.wr_ready); end
    n_cmp++; if (d !== 4'h1) begin n_fail++; $display("FAIL ot_d_old got %h want 1", d); end
    while (cyc < 143) begin
      bus.commit = (cyc == 124);
      step();
      bus.commit = 1'b0;
      n_cmp++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL ot_done_early cyc=%0d got %b want 0", cyc, bus.commit_done); end
      n_cmp++; if (d !== 4'((cyc % 24) / 4 + 1)) begin n_fail++;
        $display("FAIL ot_d_old cyc=%0d got %h want %0h", cyc, d, (cyc % 24) / 4 + 1); end
    end
    step();
    n_cmp++; if (bus.commit_done !== 1'b1) begin n_fail++; $display("FAIL ot_done got %b want 1", bus.commit_done); end
    n_cmp++; if (d !== 4'h9) begin n_fail++; $display("FAIL ot_d_new got %h want 9", d); end
    while (cyc < 168) begin
      step();
      n_cmp++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL ot_extra_done cyc=%0d got %b want 0", cyc, bus.commit_done); end
      n_cmp++; if (d !== 4'(9 - (cyc % 24) / 4)) begin n_fail++;
        $display("FAIL ot_d_new cyc=%0d got %h want %0h", cyc, d, 9 - (cyc % 24) / 4); end
    end
    n_cmp++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL ot_tick2 got %b want 1", frame_tick); end
  endtask

  task automatic test_disable_pending;
    wr_slot(3'd0, 4'h2);
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL dis_ready got %b want 0", bus.wr_ready); end
    step();
    step();
    enable = 1'b0;
    step();
    n_cmp++; if (seg_sel !== 6'h00) begin n_fail++; $display("FAIL dis_sel got %h want 00", seg_sel); end
    n_cmp++; if (d !== 4'h0) begin n_fail++; $display("FAIL dis_d got %h want 0", d); end
    n_cmp++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL dis_done_early got %b want 0", bus.commit_done); end
    step();
    n_cmp++; if (bus.commit_done !== 1'b1) begin n_fail++; $display("FAIL dis_done got %b want 1", bus.commit_done); end
    n_cmp++; if (seg_sel !== 6'h00) begin n_fail++; $display("FAIL dis_sel2 got %h want 00", seg_sel); end
    step();
    n_cmp++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL dis_done_once got %b want 0", bus.commit_done); end
    n_cmp++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL dis_ready2 got %b want 1", bus.wr_ready); end
    while (cyc < 200) begin
      step();
      n_cmp++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL dis_tick cyc=%0d got %b want 0", cyc, frame_tick); end
    end
    enable = 1'b1;
    step();
    n_cmp++; if (seg_sel !== 6'h20) begin n_fail++; $display("FAIL dis_resume_sel got %h want 20", seg_sel); end
    n_cmp++; if (d !== 4'h2) begin n_fail++; $display("FAIL dis_resume_d got %h want 2", d); end
  endtask

  task automatic test_wr_addr_ignored;
    int slot;
    logic [3:0] ed;
    n_cmp++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL ign_ready got %b want 1", bus.wr_ready); end
    wr_slot(3'd7, 4'h9);
    n_cmp++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL ign_ready2 got %b want 1", bus.wr_ready); end
    wr_slot(3'd6, 4'h9);
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    while (cyc < 224) step();
    step();
    n_cmp++; if (bus.commit_done !== 1'b1) begin n_fail++; $display("FAIL ign_done got %b want 1", bus.commit_done); end
    n_cmp++; if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL ign_tick got %b want 1", frame_tick); end
    for (int i = 0; i < 24; i++) begin
      if (i > 0) step();
      slot = (cyc - 225) / 4;
      ed = (slot == 0) ? 4'h2 : 4'(9 - slot);
      n_cmp++; if (d !== ed) begin n_fail++; $display("FAIL ign_d cyc=%0d got %h want %h", cyc, d, ed); end
      n_cmp++; if (seg_sel !== (6'h20 >> slot)) begin n_fail++;
        $display("FAIL ign_sel cyc=%0d got %h want %h", cyc, seg_sel, 6'h20 >> slot); end
    end
  endtask

  task automatic test_reset_mid_commit;
    wr_slot(3'd0, 4'h5);
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL rmc_pend got %b want 0", bus.wr_ready); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rmc_ready got %b want 1", bus.wr_ready); end
    n_cmp++; if (seg_sel !== 6'h00) begin n_fail++; $display("FAIL rmc_sel got %h want 00", seg_sel); end
    n_cmp++; if (d !== 4'h0) begin n_fail++; $display("FAIL rmc_d got %h want 0", d); end
    n_cmp++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL rmc_done got %b want 0", bus.commit_done); end
    step();
    step();
    enable = 1'b0;
    reset = 1'b0;
    repeat (2) begin
      step();
      n_cmp++; if (bus.commit_done !== 1'b0) begin n_fail++; $display("FAIL rmc_done_after cyc=%0d got %b want 0", cyc, bus.commit_done); end
    end
    enable = 1'b1;
    step();
    n_cmp++; if (d !== 4'h0) begin n_fail++; $display("FAIL rmc_active_clr got %h want 0", d); end
  endtask

`ifdef SEG_LZB_EN
  task automatic test_lzb;
    int slot;
    logic [5:0] es;
    logic [3:0] ed;
    enable = 1'b0;
    step();
    for (int k = 0; k < 6; k++) wr_slot(3'(k), (k == 2) ? 4'h3 : 4'h0);
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    step();
    n_cmp++; if (bus.commit_done !== 1'b1) begin n_fail++; $display("FAIL lzb_done got %b want 1", bus.commit_done); end
    enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      slot = i / 4;
      es = (slot < 2) ? 6'h00 : (6'h20 >> slot);
      ed = (slot == 2) ? 4'h3 : 4'h0;
      n_cmp++; if (seg_sel !== es) begin n_fail++; $display("FAIL lzb_sel i=%0d got %h want %h", i, seg_sel, es); end
      n_cmp++; if (d !== ed) begin n_fail++; $display("FAIL lzb_d i=%0d got %h want %h", i, d, ed); end
    end
  endtask
`endif

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 3'd0;
    bus.wr_data  = 4'h0;
    bus.commit   = 1'b0;
    test_reset();
    test_scan();
    test_commit();
    test_commit_on_tick();
    test_disable_pending();
    test_wr_addr_ignored();
    test_reset_mid_commit();
`ifdef SEG_LZB_EN
    test_lzb();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 1023, clk cycles per digit slot minus one (legal 1..1023).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port enable  input  1  high = scan display, low = display off.
REQ-005 SHALL have port wr_valid  input  1  shadow-digit write request.
REQ-006 SHALL have port wr_ready  output  1  shadow write accepted when wr_valid&wr_ready.
REQ-007 SHALL have port wr_addr  input  3  digit slot 0..5; 6..7 are ignored.
REQ-008 SHALL have port wr_data  input  4  digit value.
REQ-009 SHALL have port commit  input  1  one-cycle request to copy shadow to active.
REQ-010 SHALL have port commit_done  output  1  one-cycle pulse when the copy happens.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse at each digit-5-to-digit-0 wrap.
REQ-012 SHALL have port d  output  4  value driven for the selected digit.
REQ-013 SHALL have port seg_sel  output  6  one-hot digit select; slot k drives bit 5-k (slot 0 = 6'h20, slot 5 = 6'h01).

Function
REQ-014 SHALL implement FSM states IDLE and SCAN; IDLE->SCAN when enable=1, SCAN->IDLE when enable=0, both taking effect on the next clock edge.
REQ-015 SHALL, in IDLE, hold the prescaler and digit index at 0 and drive seg_sel=6'h00 and d=4'h0.
REQ-016 SHALL, in SCAN, count the prescaler 0..PRESCALE; at PRESCALE it wraps to 0 and the digit index advances 0->1->...->5->0.
REQ-017 SHALL drive d and seg_sel from registers; they update on the same edge as the digit index, so the first SCAN cycle shows slot 0 (6'h20, active[0]).
REQ-018 SHALL assert frame_tick for exactly one cycle, on the edge where the index wraps 5->0.
REQ-019 SHALL hold six 4-bit shadow registers and six 4-bit active registers; the display reads only the active registers.
REQ-020 SHALL write wr_data into shadow[wr_addr] on wr_valid&wr_ready.
REQ-021 SHALL accept and discard writes with wr_addr 6 or 7, without raising an error.
REQ-022 SHALL set a pending flag on commit=1 when pending is 0; wr_ready SHALL equal !pending.
REQ-023 SHALL ignore commit while pending is 1.
REQ-024 SHALL, in SCAN, copy all six shadow registers to the active registers on the frame_tick edge; commit_done pulses on that edge and pending clears.
REQ-025 SHALL, in IDLE, apply a pending commit on the next clock edge (no frame wait) and pulse commit_done.
REQ-026 SHALL, when wr_valid&wr_ready and commit coincide, include the write in the committed data.
REQ-027 SHALL defer a commit that arrives on the same edge as frame_tick to the following frame boundary.
REQ-028 SHALL, when enable drops mid-frame, abandon the frame with no frame_tick; a pending commit then completes per REQ-025.

Reset
REQ-029 SHALL, on reset, enter IDLE and clear prescaler, index, pending, shadow and active registers to 0.
REQ-030 SHALL hold these values during reset: d=4'h0, seg_sel=6'h00, frame_tick=0, commit_done=0, wr_ready=1.
REQ-031 SHALL, on reset mid-commit, drop the pending commit without a commit_done pulse.

Configuration
REQ-032 SHALL, with macro SEG_LZB_EN defined, blank leading zeros: slot k<5 drives seg_sel=6'h00 and d=4'h0 in its slot when active[0..k] are all 0; slot timing and frame_tick are unchanged.
REQ-033 SHALL, without SEG_LZB_EN, display all six slots unconditionally.

Verification (PRESCALE=3)
REQ-034 SHALL check reset release with enable=1: seg_sel sequence 20,10,08,04,02,01, each held 4 cycles, with d=0 throughout; frame_tick pulses every 24 cycles.
REQ-035 SHALL check a write of 1..6 to slots 0..5 then commit: wr_ready goes low; there is no display change before frame_tick; on the frame_tick edge commit_done=1 and then d shows 1..6.
REQ-036 SHALL check a commit on the frame_tick edge: it is applied one frame (24 cycles) later, and a second commit while pending produces no extra commit_done.
REQ-037 SHALL check enable=0 mid-frame with commit pending: the next edge gives seg_sel=0 and d=0, commit_done pulses one cycle later, and there is no frame_tick.
REQ-038 SHALL check wr_addr=7 with data 9: the write is accepted and no active or shadow slot changes.
REQ-039 SHALL check, with SEG_LZB_EN, active=0,0,3,0,0,0: slots 0-1 are blank (seg_sel=0) and slots 2-5 show 3,0,0,0.
